ac97_frame_receiver: RTL
========================

# ac97_frame_receiver

Deserializer for the AC97 codec-to-controller serial stream (AC97SDI). Runs on AC97BitClock alongside the AC97 command controller and frames on that controller's AC97Sync output. Extracts the slot-0 tag, the status register readback (slots 1–2) and the stereo PCM capture sample (slots 3–4). Presents them as registered words with one-cycle strobes for downstream capture logic and register-readback checking.

## Interface
Parameters: none.
- AC97BitClock  input  1   codec bit clock (12.288 MHz); sole clock
- Reset  input  1   synchronous, active-high
- AC97SDI  input  1   serial data from codec, MSB-first
- AC97Sync  input  1   frame sync from AC97 controller; high for bits 0–15 of each 256-bit frame
- CodecReady  output  1   tag bit 0 of the most recent frame
- StatusAddr  output  7   slot 1 bits 18:12 (register index read back)
- StatusData  output  16  slot 2 bits 19:4
- StatusValid  output  1   one-cycle strobe: StatusAddr/StatusData updated
- PCMLeft  output  20  slot 3, two's complement
- PCMRight  output  20  slot 4, two's complement
- SampleValid  output  1   one-cycle strobe: PCMLeft/PCMRight updated
- Locked  output  1   frame alignment verified
- FrameError  output  1   one-cycle strobe on framing violation
- ErrorCount  output  8   saturating count of FrameError strobes

## Operation
- Sampling: every AC97BitClock rising edge samples AC97SDI and AC97Sync. SyncPrev register holds the previous AC97Sync.
- Sync edge: AC97Sync=1 and SyncPrev=0 at an edge. The SDI sampled at that edge is frame bit 0. BitCount (8 bit) loads 1.
- Otherwise in ACQUIRE/LOCKED: BitCount increments mod 256. The sampled bit index = BitCount before the edge.
- States:
  - IDLE: no capture, BitCount held 0.
  - ACQUIRE: first frame after a sync edge.
  - LOCKED: alignment verified.
- Transitions:
  - IDLE → ACQUIRE on sync edge.
  - ACQUIRE/LOCKED, sync edge with BitCount==0 (exactly 256 bits since last edge) → LOCKED.
  - ACQUIRE/LOCKED, sync edge with BitCount≠0 → FrameError, realign (bit 0 taken), state ACQUIRE.
  - ACQUIRE/LOCKED, BitCount==0 and no sync edge → FrameError, state IDLE.
- Locked = (state==LOCKED).
- Tag (bits 0–15, shifted into a 16-bit register): bit 0 codec ready, bit 1..4 slot 1..4 valid.
- Slot n (1–4) occupies frame bits 16+20(n−1) .. 35+20(n−1), MSB first. Capture uses a 20-bit shift register.
- CodecReady updates at the edge sampling bit 0.
- At the edge sampling bit 55: if tag ready, slot1-valid and slot2-valid are all set, load StatusAddr/StatusData and pulse StatusValid.
- At the edge sampling bit 95: if tag ready, slot3-valid and slot4-valid are all set, load PCMLeft/PCMRight and pulse SampleValid.
- Bits 96–255 are ignored.
- ErrorCount: +1 per FrameError, saturates at 255. Cleared only by Reset.
- Strobes are suppressed in IDLE. They are permitted in ACQUIRE and LOCKED.

## Timing
- Reset (any point, including mid-frame): all outputs 0, state IDLE, BitCount 0, SyncPrev 0. The next sync edge after Reset deasserts starts capture.
- Latency:
  - CodecReady is valid the cycle after bit 0 is sampled.
  - StatusValid is high for exactly the cycle after bit 55 is sampled.
  - SampleValid is high for exactly the cycle after bit 95 is sampled.
  - Data words change only together with their strobe and hold until the next strobe.
- Locked rises the cycle after the second correctly spaced sync edge (257 edges after the first).
- FrameError is high the cycle after the offending edge. A sync edge arriving early re-frames on that same edge (no bit lost).
- Simultaneous Reset and sync edge: Reset wins, state IDLE.
- AC97Sync held high beyond bit 15 is not an error. Only rising edges frame.

## Test plan
- Reset mid-frame (bit 40) → all outputs 0 next cycle; no strobes until the next sync edge plus 56 edges.
- Two frames with tag 0xF800, slot1=0x02000, slot2=0x0A0A0, slot3=0x7FFFF, slot4=0x80000:
  - StatusAddr=0x02, StatusData=0x0A0A, StatusValid pulse in frame 1.
  - PCMLeft=0x7FFFF, PCMRight=0x80000, SampleValid pulse in frame 1.
  - Locked=1 after the second sync edge.
- Tag 0xE000 (slots 3/4 invalid) → no SampleValid. StatusValid still pulses. PCM words unchanged.
- Sync edge after 200 bits while LOCKED → FrameError pulse, ErrorCount=1, Locked=0. The following frame of 256 bits restores Locked=1.
- Sync missing at bit 256 → FrameError, state IDLE, no strobes until the next sync edge.
- 300 consecutive misaligned sync edges → ErrorCount saturates at 255.

Source files
------------

// File: rtl/ac97_frame_receiver.sv
// AC97 codec-to-controller deserializer: frames on AC97Sync rising edges and
// extracts the slot-0 tag, status readback (slots 1-2) and PCM capture (slots 3-4).
module ac97_frame_receiver (
  input  logic        AC97BitClock,
  input  logic        Reset,
  input  logic        AC97SDI,
  input  logic        AC97Sync,
  output logic        CodecReady,
  output logic [6:0]  StatusAddr,
  output logic [15:0] StatusData,
  output logic        StatusValid,
  output logic [19:0] PCMLeft,
  output logic [19:0] PCMRight,
  output logic        SampleValid,
  output logic        Locked,
  output logic        FrameError,
  output logic [7:0]  ErrorCount
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        sync_prev;
  logic        sync_edge;
  logic [7:0]  bit_count, bit_count_next;
  logic [7:0]  bit_idx;
  logic        capture;
  logic        frame_err;
  logic [15:0] tag_sr;
  logic [19:0] slot_sr;
  logic [6:0]  slot1_addr;
  logic [19:0] slot3_word;
  logic        status_hit;
  logic        sample_hit;

  assign sync_edge = AC97Sync & ~sync_prev;

  // A sync edge always frames bit 0; otherwise the bit index is the count
  // before the edge, and a count of 0 without a sync edge means bit 256.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    state_next     = state;
    bit_count_next = bit_count;
    bit_idx        = bit_count;
    capture        = 1'b0;
    frame_err      = 1'b0;
    case (state)
      IDLE: begin
        if (sync_edge) begin
          state_next     = ACQUIRE;
          bit_count_next = 8'd1;
          bit_idx        = 8'd0;
          capture        = 1'b1;
        end
      end
      ACQUIRE, LOCKED: begin
        if (sync_edge) begin
          bit_count_next = 8'd1;
          bit_idx        = 8'd0;
          capture        = 1'b1;
          if (bit_count == 8'd0) begin
            state_next = LOCKED;
          end else begin
            frame_err  = 1'b1;
            state_next = ACQUIRE;
          end
        end else if (bit_count == 8'd0) begin
          frame_err      = 1'b1;
          state_next     = IDLE;
          bit_count_next = 8'd0;
        end else begin
          capture        = 1'b1;
          bit_count_next = bit_count + 8'd1;
        end
      end
      default: begin
        state_next     = IDLE;
        bit_count_next = 8'd0;
      end
    endcase
  end

  // tag_sr[15] = codec ready, tag_sr[14:11] = slot 1..4 valid once bits 0-15 are in.
  assign status_hit = capture && (bit_idx == 8'd55) && tag_sr[15] && tag_sr[14] && tag_sr[13];
  assign sample_hit = capture && (bit_idx == 8'd95) && tag_sr[15] && tag_sr[12] && tag_sr[11];

  always_ff @(posedge AC97BitClock) begin
    if (Reset) begin
      state       <= IDLE;
      sync_prev   <= 1'b0;
      bit_count   <= 8'd0;
      tag_sr      <= 16'd0;
      slot_sr     <= 20'd0;
      slot1_addr  <= 7'd0;
      slot3_word  <= 20'd0;
      CodecReady  <= 1'b0;
      StatusAddr  <= 7'd0;
      StatusData  <= 16'd0;
      StatusValid <= 1'b0;
      PCMLeft     <= 20'd0;
      PCMRight    <= 20'd0;
      SampleValid <= 1'b0;
      Locked      <= 1'b0;
      FrameError  <= 1'b0;
      ErrorCount  <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      sync_prev   <= AC97Sync;
      state       <= state_next;
      bit_count   <= bit_count_next;
      Locked      <= (state_next == LOCKED);
      FrameError  <= frame_err;
      StatusValid <= status_hit;
      SampleValid <= sample_hit;
      if (frame_err && (ErrorCount != 8'hFF)) begin
        ErrorCount <= ErrorCount + 8'd1;
      end

      if (capture) begin
        slot_sr <= {slot_sr[18:0], AC97SDI};
        if (bit_idx == 8'd0) begin
          tag_sr     <= {15'd0, AC97SDI};
          CodecReady <= AC97SDI;
        end else if (bit_idx < 8'd16) begin
          tag_sr <= {tag_sr[14:0], AC97SDI};
        end
        // Completed slot word is {slot_sr[18:0], AC97SDI}; slot 1 bits 18:12 sit at slot_sr[17:11].
        if (bit_idx == 8'd35) begin
          slot1_addr <= slot_sr[17:11];
        end
        if (bit_idx == 8'd75) begin
          slot3_word <= {slot_sr[18:0], AC97SDI};
        end
      end

      if (status_hit) begin
        StatusAddr <= slot1_addr;
        StatusData <= slot_sr[18:3];
      end
      if (sample_hit) begin
        PCMLeft  <= slot3_word;
        PCMRight <= {slot_sr[18:0], AC97SDI};
      end
    end
  end

endmodule
